graph_edge_streamer: RTL
========================

GRAPH_EDGE_STREAMER -- requirements
Module: graph_edge_streamer

Interface
REQ-001 Parameter PARAM_NODE_IDX_WIDTH, default 10, is the node index width.
REQ-002 Parameter PARAM_COUNTER_WIDTH, default 4, is the per-node edge count width.
REQ-003 Parameter PARAM_EDGE_ADDR_WIDTH, default 12, is the edge memory address width.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cfg_node_wr_en  input  1  write one node-table entry.
REQ-007 cfg_node_idx  input  PARAM_NODE_IDX_WIDTH  node-table write index.
REQ-008 cfg_node_base  input  PARAM_EDGE_ADDR_WIDTH  first edge address of the node.
REQ-009 cfg_node_count  input  PARAM_COUNTER_WIDTH  number of outgoing edges of the node.
REQ-010 cfg_edge_wr_en  input  1  write one edge-memory entry.
REQ-011 cfg_edge_addr  input  PARAM_EDGE_ADDR_WIDTH  edge-memory write address.
REQ-012 cfg_edge_data  input  PARAM_NODE_IDX_WIDTH  destination node index stored at that address.
REQ-013 req_valid  input  1  lookup request present.
REQ-014 req_ready  output  1  block accepts a lookup this cycle.
REQ-015 req_node_idx  input  PARAM_NODE_IDX_WIDTH  node whose edges are requested.
REQ-016 edge_valid  output  1  next_node_idx/next_node_counter are valid.
REQ-017 edge_ready  input  1  consumer takes the current edge.
REQ-018 next_node_idx  output  PARAM_NODE_IDX_WIDTH  destination of the current edge.
REQ-019 next_node_counter  output  PARAM_COUNTER_WIDTH  edges remaining including the current one.
REQ-020 edge_last  output  1  current edge is the final response for the request.

Function
REQ-021 The block SHALL hold a node table (base, count) of 2^PARAM_NODE_IDX_WIDTH entries and an edge memory of 2^PARAM_EDGE_ADDR_WIDTH entries.
REQ-022 FSM states SHALL be IDLE, LOOKUP, STREAM; IDLE->LOOKUP on req accept, LOOKUP->STREAM always, STREAM->IDLE on handshake with edge_last=1.
REQ-023 req_ready SHALL be 1 only in IDLE with both cfg write enables low; accept = req_valid & req_ready.
REQ-024 Config writes SHALL be applied only in IDLE; writes presented in LOOKUP or STREAM are dropped; node and edge writes in the same cycle both apply.
REQ-025 In LOOKUP the block SHALL register base and count of the accepted node; first edge_valid appears two cycles after the accept edge.
REQ-026 In STREAM edge_valid SHALL be 1, next_node_idx = edge memory at current address, next_node_counter = remaining count.
REQ-027 On edge_valid & edge_ready the address SHALL increment modulo 2^PARAM_EDGE_ADDR_WIDTH and the remaining count decrement by 1.
REQ-028 edge_last SHALL be 1 when remaining count is 1, or when count is 0.
REQ-029 A node with count 0 SHALL yield exactly one response: next_node_idx=0, next_node_counter=0, edge_last=1.
REQ-030 Outputs SHALL hold stable while edge_valid=1 and edge_ready=0.
REQ-031 A request whose node was never written SHALL behave as count 0.

Reset
REQ-032 While rst_n=0: state IDLE, edge_valid=0, edge_last=0, next_node_idx=0, next_node_counter=0, req_ready=0, all node-table entries zero.
REQ-033 Edge memory contents SHALL NOT be reset.
REQ-034 Reset asserted mid-STREAM SHALL abort the request immediately; after release the block is in IDLE with req_ready=1 and no residual edge_valid.

Verification
REQ-035 Node 5 = (base 10, count 3), edges 10..12 = 7,9,42; request 5, edge_ready=1 -> valid at accept+2, outputs (7,3,0),(9,2,0),(42,1,1), then req_ready=1.
REQ-036 Same setup, edge_ready toggles 1,0,0,1 -> each edge held unchanged while stalled; exactly 3 handshakes total.
REQ-037 Request unwritten node 100 -> single response (0,0,last=1), then back to IDLE.
REQ-038 Node 1 = (base 4094, count 3), edges 4094,4095,0 = 3,4,5 -> outputs 3,4,5 in order (address wraps).
REQ-039 req_valid with cfg_node_wr_en high in IDLE -> req_ready=0, write applied; request accepted next cycle, returns new data. cfg write during STREAM -> table unchanged.
REQ-040 rst_n pulsed low after first edge of REQ-035 -> edge_valid=0 at once; after release, node table cleared and node 5 returns count 0.

Source files
------------

// File: rtl/graph_edge_streamer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// graph_edge_streamer_if : config, request and edge-stream signals of the streamer
// Revision: 1.0
// ----------------------------------------------------------------------------
interface graph_edge_streamer_if #(
  parameter int PARAM_NODE_IDX_WIDTH  = 10,
  parameter int PARAM_COUNTER_WIDTH   = 4,
  parameter int PARAM_EDGE_ADDR_WIDTH = 12
);
  logic                             cfg_node_wr_en;
  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_node_idx;
  logic [PARAM_EDGE_ADDR_WIDTH-1:0] cfg_node_base;
  logic [PARAM_COUNTER_WIDTH-1:0]   cfg_node_count;
  logic                             cfg_edge_wr_en;
  logic [PARAM_EDGE_ADDR_WIDTH-1:0] cfg_edge_addr;
  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_edge_data;
  logic                             req_valid;
  logic                             req_ready;
  logic [PARAM_NODE_IDX_WIDTH-1:0]  req_node_idx;
  logic                             edge_valid;
  logic                             edge_ready;
  logic [PARAM_NODE_IDX_WIDTH-1:0]  next_node_idx;
  logic [PARAM_COUNTER_WIDTH-1:0]   next_node_counter;
  logic                             edge_last;

  modport master (
    output cfg_node_wr_en, cfg_node_idx, cfg_node_base, cfg_node_count,
    output cfg_edge_wr_en, cfg_edge_addr, cfg_edge_data,
    output req_valid, req_node_idx, edge_ready,
    input  req_ready, edge_valid, next_node_idx, next_node_counter, edge_last
  );

  modport slave (
    input  cfg_node_wr_en, cfg_node_idx, cfg_node_base, cfg_node_count,
    input  cfg_edge_wr_en, cfg_edge_addr, cfg_edge_data,
    input  req_valid, req_node_idx, edge_ready,
    output req_ready, edge_valid, next_node_idx, next_node_counter, edge_last
  );
endinterface
`default_nettype wire

// File: rtl/graph_edge_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// graph_edge_streamer : looks up a node's edge list and streams its destinations
// Revision: 1.0
// ----------------------------------------------------------------------------
module graph_edge_streamer #(
  parameter int PARAM_NODE_IDX_WIDTH  = 10,
  parameter int PARAM_COUNTER_WIDTH   = 4,
  parameter int PARAM_EDGE_ADDR_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  graph_edge_streamer_if.slave bus
);
  localparam int NUM_NODES = 1 << PARAM_NODE_IDX_WIDTH;
  localparam int NUM_EDGES = 1 << PARAM_EDGE_ADDR_WIDTH;
  localparam logic [PARAM_EDGE_ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [PARAM_COUNTER_WIDTH-1:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PARAM_EDGE_ADDR_WIDTH-1:0] base_mem  [NUM_NODES];
  logic [PARAM_COUNTER_WIDTH-1:0]   count_mem [NUM_NODES];
  logic [NUM_NODES-1:0]             node_valid;
  logic [PARAM_NODE_IDX_WIDTH-1:0]  edge_mem  [NUM_EDGES];

  logic [PARAM_NODE_IDX_WIDTH-1:0]  req_idx;
  logic [PARAM_EDGE_ADDR_WIDTH-1:0] cur_addr;
  logic [PARAM_COUNTER_WIDTH-1:0]   remaining;

  logic                             cfg_open;
  logic                             accept;
  logic                             fire;
  logic                             req_ready;
  logic                             edge_valid;
  logic                             edge_last;
  logic [PARAM_NODE_IDX_WIDTH-1:0]  next_node_idx;
  logic [PARAM_COUNTER_WIDTH-1:0]   next_node_counter;

  assign cfg_open = (state == IDLE);
  assign accept   = bus.req_valid & req_ready;
  assign fire     = edge_valid & bus.edge_ready;

  // The valid bit stands in for clearing the whole table: an entry that is not
  // valid reads as (base 0, count 0), so the table RAM itself needs no reset.
  always_ff @(posedge clk) begin
    if (cfg_open && bus.cfg_node_wr_en) begin
      base_mem[bus.cfg_node_idx]  <= bus.cfg_node_base;
      count_mem[bus.cfg_node_idx] <= bus.cfg_node_count;
    end
    if (cfg_open && bus.cfg_edge_wr_en) begin
      edge_mem[bus.cfg_edge_addr] <= bus.cfg_edge_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      node_valid <= '0;
      req_idx    <= '0;
      cur_addr   <= '0;
      remaining  <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_open && bus.cfg_node_wr_en) begin
        node_valid[bus.cfg_node_idx] <= 1'b1;
      end
      if (accept) begin
        req_idx <= bus.req_node_idx;
      end
      if (state == LOOKUP) begin
        cur_addr  <= node_valid[req_idx] ? base_mem[req_idx] : '0;
        remaining <= node_valid[req_idx] ? count_mem[req_idx] : '0;
      end else if (fire) begin
        cur_addr  <= cur_addr + ADDR_ONE;
        remaining <= remaining - CNT_ONE;
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    req_ready         = 1'b0;
    edge_valid        = 1'b0;
    edge_last         = 1'b0;
    next_node_idx     = '0;
    next_node_counter = '0;
    unique case (state)
      IDLE: begin
        req_ready = rst_n & ~bus.cfg_node_wr_en & ~bus.cfg_edge_wr_en;
        if (bus.req_valid && req_ready) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        state_nxt = STREAM;
      end
      STREAM: begin
        edge_valid        = 1'b1;
        next_node_counter = remaining;
        // An empty node still produces one terminating response.
        if (remaining == '0) begin
          edge_last = 1'b1;
        end else begin
          next_node_idx = edge_mem[cur_addr];
          edge_last     = (remaining == CNT_ONE);
        end
        if (bus.edge_ready && edge_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.req_ready         = req_ready;
  assign bus.edge_valid        = edge_valid;
  assign bus.edge_last         = edge_last;
  assign bus.next_node_idx     = next_node_idx;
  assign bus.next_node_counter = next_node_counter;
endmodule
`default_nettype wire
